incr_count_stage: RTL and testbench

- Sequential counting stage built around an 8-bit controlled-increment datapath.
- Accepts increment-request events over a valid/ready handshake and keeps a running count register.
- For each accepted event, applies +inc to the count and emits one result word (count, carry, saturation flag) through a 2-entry skid buffer to the downstream consumer.
- Sits between the event source (decoder/control) and the result consumer in the adder subsystem.

---
 rtl/adder_pkg.sv | 21 ++
 rtl/incr_skid_buf.sv | 66 ++++++
 rtl/incr_count_stage.sv | 107 ++++++++++
 tb/tb_incr_count_stage.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder subsystem: counting-stage FSM encoding,
// result record layout and statistic width.
package adder_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SAT  = 2'd2
  } cnt_state_e;

  // Result record as carried through the skid buffer: {sat, carry, data}.
  typedef struct packed {
    logic              sat;
    logic              carry;
    logic [DATA_W-1:0] data;
  } res_rec_t;

endpackage

// File: rtl/incr_skid_buf.sv
// Two-entry valid/ready buffer for result records; ready_o is a registered
// "at most one entry held" flag so the producer never sees a full-path timing arc.
module incr_skid_buf #(
  parameter int unsigned PW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [PW-1:0] push_data_i,
  output logic          ready_o,
  output logic          valid_o,
  input  logic          pop_i,
  output logic [PW-1:0] data_o
);

  logic [PW-1:0] m0_q, m0_d, m1_q, m1_d;
  logic          v0_q, v0_d, v1_q, v1_d;
  logic          ready_q, ready_d;
  logic          pop;

  assign pop = pop_i & v0_q;

  // Slot 0 is always the head; a pop shifts slot 1 forward before any push lands.
  always_comb begin
    m0_d = m0_q;
    m1_d = m1_q;
    v0_d = v0_q;
    v1_d = v1_q;
    if (pop) begin
      m0_d = m1_q;
      v0_d = v1_q;
      v1_d = 1'b0;
    end
    if (push_i) begin
      if (!v0_d) begin
        m0_d = push_data_i;
        v0_d = 1'b1;
      end else begin
        m1_d = push_data_i;
        v1_d = 1'b1;
      end
    end
    ready_d = ~(v0_d & v1_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m0_q    <= '0;
      m1_q    <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      m0_q    <= m0_d;
      m1_q    <= m1_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = v0_q;
  assign data_o  = m0_q;

endmodule

// File: rtl/incr_count_stage.sv
// Counting stage: accepts increment events, updates a running count and emits
// {sat, carry, count} records through a 2-entry skid buffer.
// Optional accepted-increment statistic enabled by INCR_COUNT_STAT_EN.
module incr_count_stage
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_W,
  parameter bit          WRAP    = 1'b1,
  parameter int unsigned CLR_VAL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              ev_valid,
  input  logic              ev_inc,
  output logic              ev_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_data,
  output logic              res_carry,
  output logic              res_sat,
  output logic [STAT_W-1:0] stat_incs
);

  localparam int unsigned      PW       = WIDTH + 2;
  localparam logic [WIDTH-1:0] CNT_INIT = WIDTH'(CLR_VAL);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  cnt_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   sum;
  logic             accept, buf_ready, push_sat, push_carry;
  logic [PW-1:0]    push_rec, out_rec;

  // clr blocks acceptance in the same cycle so the source retries the event.
  assign ev_ready = buf_ready & ~clr;
  assign accept   = ev_valid & ev_ready;
  assign sum      = {1'b0, count_q} + (WIDTH+1)'(ev_inc);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    push_carry = 1'b0;
    push_sat   = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
      count_d = CNT_INIT;
    end else if (accept) begin
      if (WRAP) begin
        count_d    = sum[WIDTH-1:0];
        push_carry = sum[WIDTH];
        state_d    = ST_RUN;
      end else if (state_q == ST_SAT || (ev_inc && count_q == CNT_MAX)) begin
        count_d  = CNT_MAX;
        push_sat = 1'b1;
        state_d  = ST_SAT;
      end else begin
        count_d = sum[WIDTH-1:0];
        state_d = ST_RUN;
      end
    end
    push_rec = {push_sat, push_carry, count_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= CNT_INIT;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  incr_skid_buf #(.PW(PW)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .push_i      (accept),
    .push_data_i (push_rec),
    .ready_o     (buf_ready),
    .valid_o     (res_valid),
    .pop_i       (res_ready),
    .data_o      (out_rec)
  );

  assign {res_sat, res_carry, res_data} = out_rec;

`ifdef INCR_COUNT_STAT_EN
  logic [STAT_W-1:0] stat_q, stat_d;

  // Saturating count of accepted increment requests; clr does not touch it.
  always_comb begin
    stat_d = stat_q;
    if (accept && ev_inc && stat_q != '1) stat_d = stat_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat_incs = stat_q;
`else
  assign stat_incs = '0;
`endif

endmodule

// File: tb/tb_incr_count_stage.sv
// Directed bench for incr_count_stage: a wrapping and a saturating instance
// share one stimulus stream; outputs sampled on the falling edge.
module tb_incr_count_stage;

`ifdef INCR_COUNT_STAT_EN
  localparam int unsigned STAT_EXP = 10;
`else
  localparam int unsigned STAT_EXP = 0;
`endif

  logic        clk, reset, clr, ev_valid, ev_inc, res_ready;
  logic        w_ready, w_valid, w_carry, w_sat;
  logic        s_ready, s_valid, s_carry, s_sat;
  logic [7:0]  w_data, s_data;
  logic [15:0] w_stat, s_stat;
  int          n_vec, n_err, acc;

  incr_count_stage #(.WIDTH(8), .WRAP(1'b1), .CLR_VAL(0)) dut_w (
    .clk(clk), .reset(reset), .clr(clr), .ev_valid(ev_valid), .ev_inc(ev_inc),
    .ev_ready(w_ready), .res_valid(w_valid), .res_ready(res_ready),
    .res_data(w_data), .res_carry(w_carry), .res_sat(w_sat), .stat_incs(w_stat)
  );

  incr_count_stage #(.WIDTH(8), .WRAP(1'b0), .CLR_VAL(0)) dut_s (
    .clk(clk), .reset(reset), .clr(clr), .ev_valid(ev_valid), .ev_inc(ev_inc),
    .ev_ready(s_ready), .res_valid(s_valid), .res_ready(res_ready),
    .res_data(s_data), .res_carry(s_carry), .res_sat(s_sat), .stat_incs(s_stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then return at the next falling edge.
  task automatic cyc(input logic v, input logic inc, input logic c, input logic rr);
    ev_valid = v; ev_inc = inc; clr = c; res_ready = rr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    ev_valid = 1'b0; ev_inc = 1'b0; clr = 1'b0; res_ready = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0;
    do_reset();
    chk("rst_valid", w_valid, 0);
    chk("rst_data",  w_data, 0);
    chk("rst_carry", w_carry, 0);
    chk("rst_sat",   s_sat, 0);
    chk("rst_stat",  w_stat, 0);
    chk("rst_ready", w_ready, 1);

    // Three events, consumer always ready: 01, 02, 02 one cycle after acceptance.
    cyc(1, 1, 0, 1);
    chk("t1_valid0", w_valid, 1); chk("t1_data0", w_data, 8'h01); chk("t1_carry0", w_carry, 0);
    cyc(1, 1, 0, 1);
    chk("t1_data1", w_data, 8'h02); chk("t1_sat1", w_sat, 0);
    cyc(1, 0, 0, 1);
    chk("t1_data2", w_data, 8'h02); chk("t1_carry2", w_carry, 0); chk("t1_sdata2", s_data, 8'h02);
    cyc(0, 0, 0, 1);
    chk("t1_empty", w_valid, 0);

    // Boundary at all-ones: wrap with carry vs saturate.
    do_reset();
    repeat (254) cyc(1, 1, 0, 1);
    chk("t2_fe", w_data, 8'hFE);
    cyc(1, 1, 0, 1);
    chk("t2_w_ff", w_data, 8'hFF); chk("t2_w_c0", w_carry, 0);
    chk("t2_s_ff", s_data, 8'hFF); chk("t2_s_s0", s_sat, 0);
    cyc(1, 1, 0, 1);
    chk("t2_w_00", w_data, 8'h00); chk("t2_w_c1", w_carry, 1);
    chk("t2_s_ff2", s_data, 8'hFF); chk("t2_s_s1", s_sat, 1); chk("t2_s_c", s_carry, 0);
    cyc(1, 1, 0, 1);
    chk("t2_w_01", w_data, 8'h01); chk("t2_w_c2", w_carry, 0);
    chk("t2_s_ff3", s_data, 8'hFF); chk("t2_s_s2", s_sat, 1);
    cyc(1, 0, 0, 1);
    chk("t2_s_hold", s_data, 8'hFF); chk("t2_s_s3", s_sat, 1); chk("t2_w_hold", w_data, 8'h01);
    ev_valid = 1'b1; ev_inc = 1'b1; clr = 1'b1; res_ready = 1'b1;
    #1 chk("t2_clr_rdy", w_ready, 0);
    @(negedge clk);
    chk("t2_clr_none", s_valid, 0);
    cyc(1, 1, 0, 1);
    chk("t2_s_after", s_data, 8'h01); chk("t2_s_after_sat", s_sat, 0); chk("t2_w_after", w_data, 8'h01);
    cyc(0, 0, 0, 1);

    // Stall: only two events fit, head stays stable, then drains in order.
    do_reset();
    ev_valid = 1'b1; ev_inc = 1'b1; res_ready = 1'b0; acc = 0;
    for (int i = 0; i < 5; i++) begin
      #1 if (w_ready) acc++;
      if (i > 0) begin
        chk("t3_stall_v", w_valid, 1);
        chk("t3_stall_d", w_data, 8'h01);
      end
      @(negedge clk);
    end
    chk("t3_acc", acc, 2);
    chk("t3_rdy_low", w_ready, 0);
    cyc(0, 0, 0, 1);
    chk("t3_drain1", w_data, 8'h02); chk("t3_drain1_v", w_valid, 1);
    cyc(0, 0, 0, 1);
    chk("t3_drained", w_valid, 0);

    // clr with a buffered result: result survives, retried event sees CLR_VAL.
    do_reset();
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 0);
    chk("t4_buf", w_data, 8'h03);
    ev_valid = 1'b1; ev_inc = 1'b1; clr = 1'b1; res_ready = 1'b0;
    #1 chk("t4_clr_rdy", w_ready, 0);
    @(negedge clk);
    clr = 1'b0;
    #1 chk("t4_retry_rdy", w_ready, 1);
    @(negedge clk);
    chk("t4_head", w_data, 8'h03);
    cyc(0, 0, 0, 1);
    chk("t4_next", w_data, 8'h01); chk("t4_next_v", w_valid, 1);
    cyc(0, 0, 0, 1);
    chk("t4_empty", w_valid, 0);

    // Statistic: 10 increments + 4 pass-through events; clr keeps it, reset clears.
    do_reset();
    repeat (10) cyc(1, 1, 0, 1);
    repeat (4) cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t5_stat", w_stat, STAT_EXP);
    cyc(0, 0, 1, 1);
    chk("t5_stat_clr", w_stat, STAT_EXP);
    cyc(1, 1, 0, 0);
    chk("t5_pend", w_valid, 1);
    do_reset();
    chk("t5_rst_valid", w_valid, 0);
    chk("t5_rst_data", w_data, 0);
    chk("t5_rst_stat", w_stat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
